load_store_unit: RTL and testbench

// - Parametrised memory-access stage for the RISC-V pipeline. Replaces the fixed-width,

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 50 +++++
 rtl/load_store_unit_align.sv | 50 +++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared LSU constants: access-size codes, FSM state encoding and size helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } lsu_state_e;

  // Address bits that must be zero for a naturally aligned access; 2'b11 behaves as word.
  function automatic logic [1:0] size_lsb_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_lsb_mask = 2'b00;
      SZ_HALF: size_lsb_mask = 2'b01;
      default: size_lsb_mask = 2'b11;
    endcase
  endfunction

  function automatic logic [3:0] size_be(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_be = 4'h1;
      SZ_HALF: size_be = 4'h3;
      default: size_be = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and DMEM request/grant/response bundle for the LSU.
interface lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int NB = DATA_W / 8;

  logic              halt;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;
  logic              stall;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [NB-1:0]     dmem_be;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  logic              rsp_valid;
  logic [4:0]        rsp_rd;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_is_load;
  logic              rsp_err;
  logic              rsp_misalign;

  modport slave (
    input  halt, req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, stall,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output rsp_valid, rsp_rd, rsp_data, rsp_is_load, rsp_err, rsp_misalign
  );

  modport master (
    output halt, req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, stall,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  rsp_valid, rsp_rd, rsp_data, rsp_is_load, rsp_err, rsp_misalign
  );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational byte-lane steering for stores and shift/truncate/extend for loads.
// Offsets arriving here are already aligned to the access size.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [NB-1:0]     o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [NB-1:0]     w_be_base;
  logic [DATA_W-1:0] w_shift;

  always_comb begin
    w_be_base      = '0;
    w_be_base[3:0] = size_be(i_size);
    o_be           = w_be_base << i_off;
  end

  // Replicating the low bytes into every lane lets the enables alone pick the target lanes.
  always_comb begin
    o_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      case (i_size)
        SZ_BYTE: o_wdata[8*i +: 8] = i_wdata[7:0];
        SZ_HALF: o_wdata[8*i +: 8] = i_wdata[8*(i%2) +: 8];
        default: o_wdata[8*i +: 8] = i_wdata[8*(i%4) +: 8];
      endcase
    end
  end

  always_comb begin
    w_shift = i_rdata >> {i_off, 3'b000};
    case (i_size)
      SZ_BYTE: o_rdata = i_unsigned ? DATA_W'(w_shift[7:0])  : DATA_W'($signed(w_shift[7:0]));
      SZ_HALF: o_rdata = i_unsigned ? DATA_W'(w_shift[15:0]) : DATA_W'($signed(w_shift[15:0]));
      default: o_rdata = DATA_W'($signed(w_shift[31:0]));
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: request/grant/response DMEM master with stall, bus timeout and lane steering.
// Build macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 15,
  localparam int NB            = DATA_W / 8,
  localparam int OFF_W         = $clog2(NB),
  localparam int CNT_W         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              r_store;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_is_load;
  logic              r_rsp_err;
  logic              r_rsp_misalign;

  logic              w_accept;
  logic              w_ld_done;
  logic              w_tmo;
  logic              w_tmo_hit;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_addr_al;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ldata;
  logic              w_in_req;
  logic              w_in_rsp;

  assign w_addr_al = bus.req_addr & ~{{(ADDR_W-2){1'b0}}, size_lsb_mask(bus.req_size)};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = |(bus.req_addr[1:0] & size_lsb_mask(bus.req_size));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A grant without data on the last allowed cycle still times out; otherwise WAIT would outlive the budget.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ld_done   = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = w_misalign ? ST_RSP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.dmem_gnt && (r_store || bus.dmem_rvalid)) begin
          w_ld_done   = !r_store;
          w_state_nxt = ST_RSP;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RSP;
        end else if (bus.dmem_gnt) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.dmem_rvalid) begin
          w_ld_done   = 1'b1;
          w_state_nxt = ST_RSP;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (!bus.halt) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store        <= 1'b0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rd           <= '0;
      r_cnt          <= '0;
      r_rsp_data     <= '0;
      r_rsp_is_load  <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_rsp_misalign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store        <= bus.req_store;
        r_size         <= bus.req_size;
        r_unsigned     <= bus.req_unsigned;
        r_addr         <= w_addr_al;
        r_wdata        <= bus.req_wdata;
        r_rd           <= bus.req_rd;
        r_cnt          <= '0;
        r_rsp_data     <= '0;
        r_rsp_is_load  <= 1'b0;
        r_rsp_err      <= 1'b0;
        r_rsp_misalign <= w_misalign;
      end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_ld_done) begin
        r_rsp_data    <= w_ldata;
        r_rsp_is_load <= 1'b1;
      end
      if (w_tmo) r_rsp_err <= 1'b1;
    end
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_off      (r_addr[OFF_W-1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (bus.dmem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ldata)
  );

  assign w_in_req = (r_state == ST_REQ);
  assign w_in_rsp = (r_state == ST_RSP);

  assign bus.req_ready    = (r_state == ST_IDLE) && !bus.halt;
  assign bus.stall        = (r_state != ST_IDLE);
  assign bus.dmem_req     = w_in_req;
  assign bus.dmem_we      = w_in_req && r_store;
  assign bus.dmem_addr    = w_in_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.dmem_be      = w_in_req ? w_be : '0;
  assign bus.dmem_wdata   = w_in_req ? w_wdata : '0;
  assign bus.rsp_valid    = w_in_rsp;
  assign bus.rsp_rd       = w_in_rsp ? r_rd : '0;
  assign bus.rsp_data     = w_in_rsp ? r_rsp_data : '0;
  assign bus.rsp_is_load  = w_in_rsp && r_rsp_is_load;
  assign bus.rsp_err      = w_in_rsp && r_rsp_err;
  assign bus.rsp_misalign = w_in_rsp && r_rsp_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses against a reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.DATA_W(32), .ADDR_W(16)) bus();

  load_store_unit #(.DATA_W(32), .ADDR_W(16), .TIMEOUT_CYCLES(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int          o_lat;
  logic        o_req_seen, o_we, o_isld, o_err, o_mis, o_stall_ok, o_one;
  logic [15:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata, o_data;
  logic [4:0]  o_rd;

  // Drives one access from IDLE and plays the memory: grant after gd REQ cycles, data rv cycles after grant.
  task automatic xfer(input logic st, input logic [1:0] sz, input logic un, input logic [15:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input int gd, input int rv,
                      input logic [31:0] rdat);
    int cyc, nreq, gat;
    bit granted;
    o_lat = 0; o_req_seen = 0; o_we = 0; o_addr = '0; o_be = '0; o_wdata = '0;
    o_data = '0; o_isld = 0; o_err = 0; o_mis = 0; o_rd = '0; o_stall_ok = 1; o_one = 0;
    bus.req_valid = 1; bus.req_store = st; bus.req_size = sz; bus.req_unsigned = un;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd;
    @(negedge clk);
    bus.req_valid = 0; bus.req_wdata = $urandom; bus.req_addr = 16'($urandom);
    cyc = 1; nreq = 0; gat = 0; granted = 0;
    while (cyc < 60) begin
      bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = $urandom;
      if (bus.rsp_valid) begin
        o_lat = cyc; o_data = bus.rsp_data; o_isld = bus.rsp_is_load; o_err = bus.rsp_err;
        o_mis = bus.rsp_misalign; o_rd = bus.rsp_rd;
        break;
      end
      if (!bus.stall) o_stall_ok = 0;
      if (bus.dmem_req) begin
        o_req_seen = 1; o_we = bus.dmem_we; o_addr = bus.dmem_addr; o_be = bus.dmem_be;
        o_wdata = bus.dmem_wdata;
        if (nreq == gd) begin
          bus.dmem_gnt = 1; granted = 1; gat = cyc;
          if (!st && rv == 0) begin bus.dmem_rvalid = 1; bus.dmem_rdata = rdat; end
        end
        nreq++;
      end else if (granted && !st && (cyc - gat) == rv) begin
        bus.dmem_rvalid = 1; bus.dmem_rdata = rdat;
      end
      @(negedge clk);
      cyc++;
    end
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
    if (o_lat != 0) begin
      @(negedge clk);
      o_one = !bus.rsp_valid && !bus.stall && bus.req_ready;
    end
  endtask

  // Reference: natural alignment (or trap), lane enables, replicated write data, extended load value.
  function automatic void model(input logic st, input logic [1:0] sz, input logic un,
                                input logic [15:0] a, input logic [31:0] wd, input int gd,
                                input int rv, input logic [31:0] rdat,
                                output int e_lat, output logic e_req, output logic [15:0] e_addr,
                                output logic [3:0] e_be, output logic [31:0] e_wdata,
                                output logic [31:0] e_data, output logic e_isld, output logic e_mis);
    int nb, aa, off;
    longint v;
    bit trap;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(a) % nb) != 0;
`else
    trap = 0;
`endif
    e_addr = '0; e_be = '0; e_wdata = '0; e_data = '0;
    if (trap) begin
      e_lat = 1; e_req = 0; e_isld = 0; e_mis = 1;
    end else begin
      aa = int'(a) - (int'(a) % nb);
      off = aa % 4;
      e_lat = 2 + gd + (st ? 0 : rv); e_req = 1; e_isld = !st; e_mis = 0;
      e_addr = 16'(aa - off);
      e_be = 4'(((1 << nb) - 1) << off);
      e_wdata = (nb == 1) ? wd[7:0] * 32'h0101_0101 : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      if (!st) begin
        v = (longint'(rdat) >> (8 * off)) % (longint'(1) << (8 * nb));
        if (!un && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        e_data = 32'(v);
      end
    end
  endfunction

  task automatic test_reset;
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_chk++; if ({bus.stall, bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr} !== '0) begin n_fail++; $display("FAIL reset_bus: stall/req/we/be/addr got %b/%b/%b/%h/%h want all 0", bus.stall, bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr); end
    n_chk++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_misalign, bus.rsp_is_load} !== '0) begin n_fail++; $display("FAIL reset_rsp: valid %b data %h want 0", bus.rsp_valid, bus.rsp_data); end
    rst_n = 1;
    @(negedge clk);
    bus.halt = 1; #1;
    n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL halt_blocks_ready: got %b want 0", bus.req_ready); end
    bus.halt = 0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    xfer(1, 2'd2, 0, 16'h0010, 32'hDEADBEEF, 5'd3, 0, 0, 32'h0);
    n_chk++; if (o_be !== 4'hF || o_wdata !== 32'hDEADBEEF || o_we !== 1'b1) begin n_fail++; $display("FAIL sw_bus: be %h wdata %h we %b want F DEADBEEF 1", o_be, o_wdata, o_we); end
    n_chk++; if (o_lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", o_lat); end
    n_chk++; if (o_isld !== 1'b0 || o_data !== 32'h0 || o_rd !== 5'd3) begin n_fail++; $display("FAIL sw_rsp: is_load %b data %h rd %0d want 0 0 3", o_isld, o_data, o_rd); end
    n_chk++; if (o_one !== 1'b1) begin n_fail++; $display("FAIL sw_one_cycle: got %b want 1", o_one); end
  endtask

  task automatic test_load_byte;
    xfer(0, 2'd0, 0, 16'h0013, 32'h0, 5'd7, 0, 3, 32'h80FF_0000);
    n_chk++; if (o_data !== 32'hFFFFFF80 || o_isld !== 1'b1) begin n_fail++; $display("FAIL lb_data: got %h/%b want FFFFFF80/1", o_data, o_isld); end
    n_chk++; if (o_lat !== 5 || o_stall_ok !== 1'b1) begin n_fail++; $display("FAIL lb_timing: lat %0d stall_ok %b want 5 1", o_lat, o_stall_ok); end
    n_chk++; if (o_be !== 4'h8 || o_addr !== 16'h0010) begin n_fail++; $display("FAIL lb_bus: be %h addr %h want 8 0010", o_be, o_addr); end
    xfer(0, 2'd0, 1, 16'h0013, 32'h0, 5'd7, 0, 3, 32'h80FF_0000);
    n_chk++; if (o_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", o_data); end
  endtask

  task automatic test_store_half;
    xfer(1, 2'd1, 0, 16'h0002, 32'h0000_1234, 5'd1, 1, 0, 32'h0);
    n_chk++; if (o_be !== 4'hC || o_wdata !== 32'h1234_1234 || o_addr !== 16'h0000) begin n_fail++; $display("FAIL sh_bus: be %h wdata %h addr %h want C 12341234 0000", o_be, o_wdata, o_addr); end
    n_chk++; if (o_lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", o_lat); end
  endtask

  task automatic test_timeout;
    xfer(0, 2'd2, 0, 16'h0020, 32'h0, 5'd9, 0, 999, 32'h0);
    n_chk++; if (o_lat !== 16 || o_err !== 1'b1) begin n_fail++; $display("FAIL tmo_timing: lat %0d err %b want 16 1", o_lat, o_err); end
    n_chk++; if (o_data !== 32'h0 || o_isld !== 1'b0) begin n_fail++; $display("FAIL tmo_rsp: data %h is_load %b want 0 0", o_data, o_isld); end
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.dmem_rvalid = 0;
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL late_rvalid: rsp_valid %b stall %b want 0 0", bus.rsp_valid, bus.stall); end
  endtask

  task automatic test_misalign;
    xfer(0, 2'd2, 0, 16'h0006, 32'h0, 5'd4, 0, 0, 32'h1357_9BDF);
`ifdef LSU_MISALIGN_TRAP_EN
    n_chk++; if (o_req_seen !== 1'b0 || o_mis !== 1'b1 || o_lat !== 1) begin n_fail++; $display("FAIL lw_misalign_trap: req %b mis %b lat %0d want 0 1 1", o_req_seen, o_mis, o_lat); end
`else
    n_chk++; if (o_addr !== 16'h0004 || o_be !== 4'hF || o_mis !== 1'b0 || o_data !== 32'h1357_9BDF) begin n_fail++; $display("FAIL lw_misalign_align: addr %h be %h mis %b data %h want 0004 F 0 13579BDF", o_addr, o_be, o_mis, o_data); end
`endif
  endtask

  task automatic test_halt;
    bus.req_valid = 1; bus.req_store = 0; bus.req_size = 2'd2; bus.req_unsigned = 0;
    bus.req_addr = 16'h0008; bus.req_rd = 5'd12;
    @(negedge clk);
    bus.req_valid = 0; bus.dmem_gnt = 1;
    @(negedge clk);
    bus.dmem_gnt = 0; bus.halt = 1; #1;
    n_chk++; if (bus.req_ready !== 1'b0 || bus.stall !== 1'b1 || bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL halt_wait: ready %b stall %b req %b want 0 1 0", bus.req_ready, bus.stall, bus.dmem_req); end
    @(negedge clk);
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h1122_3344;
    @(negedge clk);
    bus.dmem_rvalid = 0; bus.dmem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1122_3344 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL halt_hold[%0d]: valid %b data %h ready %b want 1 11223344 0", i, bus.rsp_valid, bus.rsp_data, bus.req_ready); end
      @(negedge clk);
    end
    bus.halt = 0;
    @(negedge clk);
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL halt_release: valid %b ready %b want 0 1", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_reset_mid;
    bit saw_rsp;
    bus.req_valid = 1; bus.req_store = 1; bus.req_size = 2'd0; bus.req_addr = 16'h0005;
    bus.req_wdata = 32'hA5; bus.req_rd = 5'd2;
    @(negedge clk);
    bus.req_valid = 0;
    n_chk++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", bus.dmem_req); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: req %b stall %b want 0 0", bus.dmem_req, bus.stall); end
    #1 rst_n = 1;
    saw_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1;
    end
    n_chk++; if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp: got %b want 0", saw_rsp); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic st, un;
      logic [1:0] sz;
      logic [15:0] a, e_addr;
      logic [31:0] wd, rdat, e_wdata, e_data;
      logic [3:0] e_be;
      logic [4:0] rd;
      logic e_req, e_isld, e_mis;
      int gd, rv, e_lat;
      st = 1'($urandom_range(0, 1)); un = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 2));
      a = 16'($urandom); wd = $urandom; rdat = $urandom; rd = 5'($urandom);
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      model(st, sz, un, a, wd, gd, rv, rdat, e_lat, e_req, e_addr, e_be, e_wdata, e_data, e_isld, e_mis);
      xfer(st, sz, un, a, wd, rd, gd, rv, rdat);
      n_chk++; if (o_lat !== e_lat || o_req_seen !== e_req || o_one !== 1'b1) begin n_fail++; $display("FAIL rnd_timing[%0d]: lat %0d req %b one %b want %0d %b 1", n, o_lat, o_req_seen, o_one, e_lat, e_req); end
      n_chk++; if (o_addr !== e_addr || o_be !== e_be || o_we !== (st && e_req)) begin n_fail++; $display("FAIL rnd_bus[%0d]: addr %h be %h we %b want %h %h %b", n, o_addr, o_be, o_we, e_addr, e_be, st && e_req); end
      n_chk++; if (st && e_req && o_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o_wdata, e_wdata); end
      n_chk++; if (o_data !== e_data || o_isld !== e_isld || o_mis !== e_mis || o_err !== 1'b0 || o_rd !== rd) begin n_fail++; $display("FAIL rnd_rsp[%0d]: data %h ld %b mis %b err %b rd %0d want %h %b %b 0 %0d", n, o_data, o_isld, o_mis, o_err, o_rd, e_data, e_isld, e_mis, rd); end
    end
  endtask

  initial begin
    bus.halt = 0; bus.req_valid = 0; bus.req_store = 0; bus.req_size = 2'd0; bus.req_unsigned = 0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_timeout();
    test_misalign();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
